autosym_lambda_stage: RTL and testbench

Streaming GF(2) affine-projection stage that maps an original N_IN-bit input vector x onto the N_OUT-bit restriction input y = A·x ⊕ c, where each y bit is the parity of a programmable subset of x bits plus a constant. It sits directly upstream of the combinational autosymmetric restriction netlist (inputs x0..x33, output y0). It drives the restriction's inputs from registered y so the restriction sees a stable vector for a full cycle. The matrix is loaded row-by-row through a configuration port; vectors flow through a valid/ready pipeline.

---
 rtl/autosym_lambda_stage_if.sv | 30 +++
 rtl/autosym_lambda_stage.sv | 79 +++++++
 tb/tb_autosym_lambda_stage.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/autosym_lambda_stage_if.sv
// Bundle of the configuration port, the input/output valid/ready streams and
// the accepted-vector counter for autosym_lambda_stage.
//   slave  : the projection stage (consumes cfg/in, produces out/vec_count)
//   master : whoever drives the stage (producer, consumer and configurator)
interface autosym_lambda_stage_if #(
  parameter int unsigned N_IN  = 39,
  parameter int unsigned N_OUT = 34,
  parameter int unsigned RW    = 6
);
  logic              cfg_we;
  logic [RW-1:0]     cfg_row;
  logic [N_IN:0]     cfg_data;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [N_OUT-1:0]  out_data;
  logic [15:0]       vec_count;

  modport slave (
    input  cfg_we, cfg_row, cfg_data, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, vec_count
  );

  modport master (
    output cfg_we, cfg_row, cfg_data, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, vec_count
  );
endinterface

// File: rtl/autosym_lambda_stage.sv
// GF(2) affine projection stage: y = A*x ^ c, one registered pipeline slot.
// Each output bit i is the parity of (row mask i & x) xor'ed with the row
// constant. Rows are written through the cfg port; vectors stream through a
// valid/ready handshake with full throughput.
//
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset (matrix back to identity)
//   bus  : autosym_lambda_stage_if.slave (cfg_*, in_*, out_*, vec_count)
//
// Build option:
//   LAMBDA_CFG_STALL_EN : when defined, in_ready is held low in every cycle
//                         with cfg_we=1, so no vector is accepted during a
//                         matrix write.
module autosym_lambda_stage #(
  parameter int unsigned N_IN  = 39,
  parameter int unsigned N_OUT = 34,
  parameter int unsigned RW    = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  autosym_lambda_stage_if.slave      bus
);

  // Row layout: [N_IN-1:0] mask, [N_IN] constant.
  logic [N_IN:0]    mat_q [N_OUT];
  logic [N_OUT-1:0] y;
  logic             out_valid_q;
  logic [N_OUT-1:0] out_data_q;
  logic [15:0]      vec_count_q;
  logic             accept;
  logic             row_ok;

  // Projection uses the matrix as it stands before this edge's write.
  always_comb begin
    y = '0;
    for (int i = 0; i < int'(N_OUT); i++) begin
      y[i] = (^(mat_q[i][N_IN-1:0] & bus.in_data)) ^ mat_q[i][N_IN];
    end
  end

`ifdef LAMBDA_CFG_STALL_EN
  assign bus.in_ready = (!out_valid_q || bus.out_ready) && !bus.cfg_we;
`else
  assign bus.in_ready = !out_valid_q || bus.out_ready;
`endif

  assign accept = bus.in_valid && bus.in_ready;
  assign row_ok = 32'(bus.cfg_row) < N_OUT;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_OUT); i++) begin
        mat_q[i] <= {{N_IN{1'b0}}, 1'b1} << i;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      vec_count_q <= '0;
    end else begin
      if (bus.cfg_we && row_ok) begin
        mat_q[bus.cfg_row] <= bus.cfg_data;
      end
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= y;
        if (vec_count_q != 16'hFFFF) begin
          vec_count_q <= vec_count_q + 16'd1;
        end
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.vec_count = vec_count_q;

endmodule

// File: tb/tb_autosym_lambda_stage.sv
module tb_autosym_lambda_stage;
  localparam int NI = 39;
  localparam int NO = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  autosym_lambda_stage_if #(.N_IN(NI), .N_OUT(NO), .RW(6)) bus ();

  autosym_lambda_stage #(.N_IN(NI), .N_OUT(NO), .RW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the matrix as a set of masks/constants plus the
  // observable output slot and counter.
  logic [NI-1:0] m_mask [NO];
  logic          m_c    [NO];
  logic          m_valid;
  logic [NO-1:0] m_data;
  logic [15:0]   m_cnt;

  function automatic logic [NO-1:0] model_y(input logic [NI-1:0] x);
    logic [NO-1:0] r;
    r = '0;
    for (int i = 0; i < NO; i++) begin
      r[i] = (($countones(m_mask[i] & x) % 2) == 1) ^ m_c[i];
    end
    return r;
  endfunction

  function automatic logic model_ready();
`ifdef LAMBDA_CFG_STALL_EN
    return (!m_valid || bus.out_ready) && !bus.cfg_we;
`else
    return !m_valid || bus.out_ready;
`endif
  endfunction

  function automatic logic [NI-1:0] rnd_x();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[NI-1:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NO; i++) begin
      m_mask[i] = '0;
      m_mask[i][i] = 1'b1;
      m_c[i] = 1'b0;
    end
    m_valid = 1'b0;
    m_data  = '0;
    m_cnt   = '0;
  endtask

  // Advance the model by the current inputs, then one clock edge.
  task automatic tick();
    logic          acc;
    logic [NO-1:0] yy;
    if (rst) begin
      model_reset();
    end else begin
      acc = bus.in_valid && model_ready();
      yy  = model_y(bus.in_data);
      if (bus.cfg_we && int'(bus.cfg_row) < NO) begin
        m_mask[bus.cfg_row] = bus.cfg_data[NI-1:0];
        m_c[bus.cfg_row]    = bus.cfg_data[NI];
      end
      if (acc) begin
        m_valid = 1'b1;
        m_data  = yy;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++;
      $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin failures++;
      $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
    checks++; if (bus.vec_count !== 16'd0) begin failures++;
      $display("FAIL reset_vec_count: got %0d expected 0", bus.vec_count); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_identity();
    logic [NI-1:0] x;
    x = 39'h55_AAAA_5555;
    bus.in_data = x; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++;
      $display("FAIL ident_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_data !== x[NO-1:0]) begin failures++;
      $display("FAIL ident_data: got %h expected %h", bus.out_data, x[NO-1:0]); end
    checks++; if (bus.vec_count !== 16'd1) begin failures++;
      $display("FAIL ident_count: got %0d expected 1", bus.vec_count); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++;
      $display("FAIL ident_drain: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_affine_row();
    logic [NI-1:0] x;
    bus.cfg_we = 1'b1; bus.cfg_row = 6'd0; bus.cfg_data = {1'b1, 39'h3};
    tick();
    bus.cfg_we = 1'b0;
    x = rnd_x() | 39'h3;
    bus.in_data = x; bus.in_valid = 1'b1;
    tick();
    checks++; if (bus.out_data[0] !== 1'b1) begin failures++;
      $display("FAIL affine_11: got %b expected 1", bus.out_data[0]); end
    checks++; if (bus.out_data[NO-1:1] !== x[NO-1:1]) begin failures++;
      $display("FAIL affine_rest: got %h expected %h", bus.out_data[NO-1:1], x[NO-1:1]); end
    x = (rnd_x() & ~39'h2) | 39'h1;
    bus.in_data = x;
    tick();
    checks++; if (bus.out_data[0] !== 1'b0) begin failures++;
      $display("FAIL affine_10: got %b expected 0", bus.out_data[0]); end
    checks++; if (bus.out_data !== m_data) begin failures++;
      $display("FAIL affine_model: got %h expected %h", bus.out_data, m_data); end
    bus.in_valid = 1'b0;
    // Put row 0 back to identity.
    bus.cfg_we = 1'b1; bus.cfg_row = 6'd0; bus.cfg_data = {1'b0, 39'h1};
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [NI-1:0] x0;
    x0 = rnd_x();
    bus.in_data = x0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    bus.in_data = rnd_x();
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== x0[NO-1:0]) begin failures++;
        $display("FAIL bp_hold: got %b/%h expected 1/%h", bus.out_valid, bus.out_data,
                 x0[NO-1:0]); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++;
        $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready); end
      checks++; if (bus.vec_count !== m_cnt) begin failures++;
        $display("FAIL bp_count: got %0d expected %0d", bus.vec_count, m_cnt); end
      tick();
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== m_data) begin failures++;
        $display("FAIL bp_stream: got %b/%h expected 1/%h", bus.out_valid, bus.out_data,
                 m_data); end
      checks++; if (bus.vec_count !== m_cnt) begin failures++;
        $display("FAIL bp_stream_count: got %0d expected %0d", bus.vec_count, m_cnt); end
      bus.in_data = rnd_x();
    end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++;
      $display("FAIL bp_drain: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_collision();
    logic [NI-1:0] x;
    logic          exp_rdy;
    x = rnd_x() & ~39'h8;
    bus.out_ready = 1'b1;
    bus.cfg_we = 1'b1; bus.cfg_row = 6'd3; bus.cfg_data = {1'b1, 39'h0};
    bus.in_data = x; bus.in_valid = 1'b1;
    #1;
`ifdef LAMBDA_CFG_STALL_EN
    exp_rdy = 1'b0;
`else
    exp_rdy = 1'b1;
`endif
    checks++; if (bus.in_ready !== exp_rdy) begin failures++;
      $display("FAIL coll_in_ready: got %b expected %b", bus.in_ready, exp_rdy); end
    tick();
    bus.cfg_we = 1'b0;
`ifndef LAMBDA_CFG_STALL_EN
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data[3] !== 1'b0) begin failures++;
      $display("FAIL coll_prewrite: got %b/%b expected 1/0", bus.out_valid, bus.out_data[3]); end
`else
    checks++; if (bus.out_valid !== 1'b0) begin failures++;
      $display("FAIL coll_stalled: got %b expected 0", bus.out_valid); end
`endif
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data[3] !== 1'b1) begin failures++;
      $display("FAIL coll_postwrite: got %b/%b expected 1/1", bus.out_valid, bus.out_data[3]); end
    checks++; if (bus.out_data !== m_data) begin failures++;
      $display("FAIL coll_model: got %h expected %h", bus.out_data, m_data); end
    bus.in_valid = 1'b0;
    bus.cfg_we = 1'b1; bus.cfg_row = 6'd3; bus.cfg_data = {1'b0, 39'h8};
    tick();
    bus.cfg_we = 1'b0;
    tick();
  endtask

  task automatic test_out_of_range();
    logic [NI-1:0] x;
    bus.cfg_we = 1'b1; bus.cfg_row = 6'd34; bus.cfg_data = {1'b1, rnd_x()};
    tick();
    bus.cfg_row = 6'd63; bus.cfg_data = {1'b1, rnd_x()};
    tick();
    bus.cfg_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      x = rnd_x();
      bus.in_data = x; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      tick();
      checks++; if (bus.out_data !== x[NO-1:0]) begin failures++;
        $display("FAIL oor_identity: got %h expected %h", bus.out_data, x[NO-1:0]); end
    end
    // Saturation of the accepted-vector counter.
    for (int k = 0; k < 65540; k++) begin
      bus.in_data = rnd_x();
      tick();
    end
    checks++; if (bus.vec_count !== 16'hFFFF) begin failures++;
      $display("FAIL sat_count: got %h expected ffff", bus.vec_count); end
    checks++; if (bus.out_data !== m_data) begin failures++;
      $display("FAIL sat_data: got %h expected %h", bus.out_data, m_data); end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic will_acc;
    bus.in_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      will_acc = bus.in_valid && model_ready();
      tick();
      checks++;
      if (bus.out_valid !== m_valid || (m_valid && bus.out_data !== m_data) ||
          bus.vec_count !== m_cnt) begin
        failures++;
        $display("FAIL rand_cycle%0d: got %b/%h/%0d expected %b/%h/%0d", n, bus.out_valid,
                 bus.out_data, bus.vec_count, m_valid, m_data, m_cnt);
      end
      if (will_acc || !bus.in_valid) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_data  = rnd_x();
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.cfg_we    = ($urandom_range(0, 5) == 0);
      bus.cfg_row   = 6'($urandom_range(0, 40));
      bus.cfg_data  = {1'($urandom_range(0, 1)), rnd_x()};
      #1;
      checks++; if (bus.in_ready !== model_ready()) begin failures++;
        $display("FAIL rand_in_ready%0d: got %b expected %b", n, bus.in_ready, model_ready()); end
    end
    bus.cfg_we = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_midstream_reset();
    logic [NI-1:0] x;
    bus.cfg_we = 1'b1; bus.cfg_row = 6'd5; bus.cfg_data = {1'b1, rnd_x()};
    tick();
    bus.cfg_we = 1'b0;
    bus.in_data = rnd_x(); bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin failures++;
      $display("FAIL mrst_pre_valid: got %b expected 1", bus.out_valid); end
    rst = 1'b1;
    bus.cfg_we = 1'b1; bus.cfg_row = 6'd7; bus.cfg_data = {1'b1, rnd_x()};
    bus.in_data = rnd_x();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++;
      $display("FAIL mrst_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.vec_count !== 16'd0) begin failures++;
      $display("FAIL mrst_count: got %0d expected 0", bus.vec_count); end
    rst = 1'b0;
    bus.cfg_we = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      x = rnd_x() | 39'h20;
      bus.in_data = x;
      tick();
      checks++; if (bus.out_data !== x[NO-1:0]) begin failures++;
        $display("FAIL mrst_identity: got %h expected %h", bus.out_data, x[NO-1:0]); end
    end
    checks++; if (bus.vec_count !== 16'd2) begin failures++;
      $display("FAIL mrst_recount: got %0d expected 2", bus.vec_count); end
    bus.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    bus.cfg_we    = 1'b0;
    bus.cfg_row   = '0;
    bus.cfg_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    model_reset();
    test_reset();
    test_identity();
    test_affine_row();
    test_backpressure();
    test_collision();
    test_out_of_range();
    test_random();
    test_midstream_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
